// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator: redirect kind
// encodings and the boot/run/halt controller states.
package pc_pkg;

   localparam logic [1:0] REDIR_JMP  = 2'b00;
   localparam logic [1:0] REDIR_CALL = 2'b01;
   localparam logic [1:0] REDIR_RET  = 2'b10;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer with a top-of-stack pointer.
// A push into a full stack overwrites the oldest entry and sets the sticky
// overflow flag. Entries are data only; just the pointer, count and flag
// are reset.
module ras_stack #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] top,
   output logic         empty,
   output logic         full,
   output logic         ovf
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] tos_q;
   logic [CNT_W-1:0] cnt_q;

   assign top   = mem[tos_q];
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CNT_W'(DEPTH));

   // Pointer, occupancy and overflow tracking.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tos_q <= '0;
         cnt_q <= '0;
         ovf   <= 1'b0;
      end else if (push) begin
         tos_q <= tos_q + 1'b1;
         if (full) ovf <= 1'b1;
         else      cnt_q <= cnt_q + 1'b1;
      end else if (pop && !empty) begin
         tos_q <= tos_q - 1'b1;
         cnt_q <= cnt_q - 1'b1;
      end
   end

   // Entry storage; the slot above the current top receives the push, which
   // is also the oldest slot once the stack is full.
   always_ff @(posedge clk) begin
      if (push) mem[tos_q + 1'b1] <= push_data;
   end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator at the head of the fetch stage.
// Selects the next fetch PC (flush > halt > redirect > sequential), owns the
// return-address stack and the boot/run/halt controller. Every output is
// registered, so there is no combinational path from any input to pc_out.
// Optional macro PC_GEN_ALIGN_CHECK_EN: rejects misaligned redirect/flush
// targets, sets the sticky pc_fault flag and parks the block in HALT.
module pc_gen
   import pc_pkg::*;
#(
   parameter int                 PC_W      = 32,
   parameter logic [PC_W-1:0]    RESET_VEC = '0,
   parameter int                 STEP      = 4,
   parameter int                 RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ena,
   input  logic            flush,
   input  logic [PC_W-1:0] flush_addr,
   input  logic            halt,
   input  logic            redir_valid,
   input  logic [1:0]      redir_kind,
   input  logic [PC_W-1:0] redir_addr,
   output logic [PC_W-1:0] pc_out,
   output logic            pc_valid,
   output logic            ras_empty,
   output logic            ras_full,
   output logic            ras_ovf,
   output logic            pc_fault
);

`ifdef PC_GEN_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   localparam logic [PC_W-1:0] STEP_V     = PC_W'(STEP);
   localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(STEP - 1);

   // True when an address would be rejected by the alignment check.
   function automatic logic addr_bad(input logic [PC_W-1:0] addr);
      return ALIGN_EN && ((addr & ALIGN_MASK) != '0);
   endfunction

   state_t          state_q;
   logic            fault_q;
   logic [PC_W-1:0] ras_top;
   logic            is_call;
   logic            is_ret;
   logic            ret_hit;
   logic            tgt_bad;
   logic            run_redir;
   logic            ras_push;
   logic            ras_pop;

   // Reserved kind 11 falls through to jump/branch.
   assign is_call   = (redir_kind == REDIR_CALL);
   assign is_ret    = (redir_kind == REDIR_RET);
   assign ret_hit   = is_ret && !ras_empty;
   assign tgt_bad   = addr_bad(redir_addr);
   assign run_redir = (state_q == RUN) && ena && !flush && !halt && redir_valid;
   assign ras_push  = run_redir && is_call && !tgt_bad;
   assign ras_pop   = run_redir && ret_hit;

   ras_stack #(
      .W     (PC_W),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_out + STEP_V),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full),
      .ovf       (ras_ovf)
   );

   assign pc_fault = ALIGN_EN ? fault_q : 1'b0;

   // Controller and next-PC selection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_out   <= RESET_VEC;
         pc_valid <= 1'b0;
         state_q  <= BOOT;
         fault_q  <= 1'b0;
      end else if (flush) begin
         if (addr_bad(flush_addr)) begin
            fault_q  <= 1'b1;
            state_q  <= HALT;
            pc_valid <= 1'b0;
         end else begin
            pc_out   <= flush_addr;
            state_q  <= RUN;
            pc_valid <= 1'b1;
         end
      end else begin
         case (state_q)
            BOOT: begin
               state_q  <= RUN;
               pc_valid <= 1'b1;
            end
            RUN: begin
               if (ena) begin
                  if (halt) begin
                     state_q  <= HALT;
                     pc_valid <= 1'b0;
                  end else if (redir_valid) begin
                     if (ret_hit) begin
                        pc_out <= ras_top;
                     end else if (tgt_bad) begin
                        fault_q  <= 1'b1;
                        state_q  <= HALT;
                        pc_valid <= 1'b0;
                     end else begin
                        pc_out <= redir_addr;
                     end
                  end else begin
                     pc_out <= pc_out + STEP_V;
                  end
               end
            end
            default: begin
               // HALT: only a flush leaves this state.
               pc_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ena = 1'b1;
   logic        flush = 1'b0;
   logic [31:0] flush_addr = '0;
   logic        halt = 1'b0;
   logic        redir_valid = 1'b0;
   logic [1:0]  redir_kind = 2'b00;
   logic [31:0] redir_addr = '0;
   logic [31:0] pc_out;
   logic        pc_valid, ras_empty, ras_full, ras_ovf, pc_fault;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] m_pc;
   logic        m_valid;
   int          m_st;      // 0 boot, 1 run, 2 halt
   logic [31:0] m_ras[$];
   logic        m_ovf;
   logic        m_fault;

   pc_gen dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .flush       (flush),
      .flush_addr  (flush_addr),
      .halt        (halt),
      .redir_valid (redir_valid),
      .redir_kind  (redir_kind),
      .redir_addr  (redir_addr),
      .pc_out      (pc_out),
      .pc_valid    (pc_valid),
      .ras_empty   (ras_empty),
      .ras_full    (ras_full),
      .ras_ovf     (ras_ovf),
      .pc_fault    (pc_fault)
   );

   always #5 clk = ~clk;

   function automatic bit bad(input logic [31:0] a);
`ifdef PC_GEN_ALIGN_CHECK_EN
      return a[1:0] != 2'b00;
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_valid = 1'b0; m_st = 0;
      m_ras.delete(); m_ovf = 1'b0; m_fault = 1'b0;
   endtask

   task automatic model_step();
      logic [31:0] tgt;
      if (flush) begin
         if (bad(flush_addr)) begin
            m_fault = 1'b1; m_st = 2; m_valid = 1'b0;
         end else begin
            m_pc = flush_addr; m_st = 1; m_valid = 1'b1;
         end
      end else if (m_st == 0) begin
         m_st = 1; m_valid = 1'b1;
      end else if (m_st == 1 && ena) begin
         if (halt) begin
            m_st = 2; m_valid = 1'b0;
         end else if (redir_valid) begin
            if (redir_kind == 2'b10 && m_ras.size() > 0) begin
               m_pc = m_ras.pop_back();
            end else begin
               tgt = redir_addr;
               if (bad(tgt)) begin
                  m_fault = 1'b1; m_st = 2; m_valid = 1'b0;
               end else begin
                  if (redir_kind == 2'b01) begin
                     m_ras.push_back(m_pc + 32'd4);
                     if (m_ras.size() > 4) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1'b1;
                     end
                  end
                  m_pc = tgt;
               end
            end
         end else begin
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pc"},    pc_out,    m_pc);
      chk({tag, ".valid"}, {31'd0, pc_valid},  {31'd0, m_valid});
      chk({tag, ".empty"}, {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
      chk({tag, ".full"},  {31'd0, ras_full},  {31'd0, m_ras.size() == 4});
      chk({tag, ".ovf"},   {31'd0, ras_ovf},   {31'd0, m_ovf});
      chk({tag, ".fault"}, {31'd0, pc_fault},  {31'd0, m_fault});
   endtask

   // One clock: model predicts from current inputs, then compare after edge.
   task automatic cyc(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic drive(input bit f, input logic [31:0] fa, input bit h, input bit e,
                        input bit rv, input logic [1:0] rk, input logic [31:0] ra);
      flush = f; flush_addr = fa; halt = h; ena = e;
      redir_valid = rv; redir_kind = rk; redir_addr = ra;
   endtask

   task automatic idle();
      drive(0, 0, 0, 1, 0, 2'b00, 0);
   endtask

   initial begin
      // Reset state
      model_reset();
      #2;
      check_all("reset");
      @(posedge clk); #1;
      rst = 1'b1;
      idle();
      cyc("boot");
      chk("boot_pc0", pc_out, 32'h0);
      cyc("seq4");
      cyc("seq8");
      chk("seq_pc8", pc_out, 32'h8);
      ena = 1'b0;
      repeat (3) cyc("stall");
      chk("stall_pc8", pc_out, 32'h8);

      // Call/return nesting
      drive(1, 32'h100, 0, 1, 0, 2'b00, 0); cyc("fl100");
      drive(0, 0, 0, 1, 1, 2'b01, 32'h200); cyc("call200");
      drive(0, 0, 0, 1, 1, 2'b01, 32'h300); cyc("call300");
      drive(0, 0, 0, 1, 1, 2'b10, 32'h0);   cyc("ret1");
      chk("ret1_pc", pc_out, 32'h204);
      cyc("ret2");
      chk("ret2_pc", pc_out, 32'h104);
      chk("ret2_empty", {31'd0, ras_empty}, 32'd1);

      // RAS overflow
      for (int i = 1; i <= 5; i++) begin
         drive(0, 0, 0, 1, 1, 2'b01, 32'h1000 * i);
         cyc("ovf_call");
      end
      chk("ovf_flag", {31'd0, ras_ovf}, 32'd1);
      chk("ovf_full", {31'd0, ras_full}, 32'd1);
      for (int i = 4; i >= 1; i--) begin
         drive(0, 0, 0, 1, 1, 2'b10, 32'hDEAD0);
         cyc("ovf_ret");
         chk("ovf_ret_pc", pc_out, 32'h1000 * i + 32'h4);
      end
      drive(0, 0, 0, 1, 1, 2'b10, 32'h500); cyc("ret_empty");
      chk("ret_empty_pc", pc_out, 32'h500);

      // Wrap and priority
      drive(1, 32'hFFFF_FFFC, 0, 1, 0, 2'b00, 0); cyc("flwrap");
      idle(); cyc("wrap");
      chk("wrap_pc", pc_out, 32'h0);
      drive(0, 0, 0, 1, 1, 2'b01, 32'h600); cyc("call600");
      drive(1, 32'h80, 0, 1, 1, 2'b01, 32'h700); cyc("fl_call");
      chk("fl_call_pc", pc_out, 32'h80);
      idle(); cyc("seq84");
      drive(1, 32'h80, 0, 0, 0, 2'b00, 0); cyc("fl_noena");
      chk("fl_noena_pc", pc_out, 32'h80);

      // Halt
      drive(0, 0, 1, 1, 0, 2'b00, 0); cyc("halt");
      chk("halt_valid", {31'd0, pc_valid}, 32'd0);
      drive(0, 0, 0, 1, 1, 2'b00, 32'h900); cyc("halt_jmp");
      chk("halt_pc", pc_out, 32'h80);
      drive(1, 32'h400, 0, 1, 0, 2'b00, 0); cyc("unhalt");
      chk("unhalt_pc", pc_out, 32'h400);

      // Alignment
      drive(0, 0, 0, 1, 1, 2'b00, 32'h102); cyc("jmp102");
`ifdef PC_GEN_ALIGN_CHECK_EN
      chk("align_pc", pc_out, 32'h400);
      chk("align_fault", {31'd0, pc_fault}, 32'd1);
      rst = 1'b0; #1;
      model_reset();
      check_all("align_rst");
      @(posedge clk); #1;
      rst = 1'b1;
`else
      chk("noalign_pc", pc_out, 32'h102);
      drive(1, 32'h400, 0, 1, 0, 2'b00, 0); cyc("realign");
`endif

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         flush       = ($urandom_range(0, 15) == 0);
         flush_addr  = $urandom() & ((($urandom_range(0, 7)) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         halt        = ($urandom_range(0, 19) == 0);
         ena         = ($urandom_range(0, 4) != 0);
         redir_valid = ($urandom_range(0, 2) == 0);
         redir_kind  = 2'($urandom_range(0, 3));
         redir_addr  = $urandom() & ((($urandom_range(0, 9)) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         cyc("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
